// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, funct3 values and encodings shared by alu_op_sequencer
// ALU_OP_SEQUENCER_SRA_EN widens the pass counter for the three-pass SRA build.
package alu_seq_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_LTU  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_XOR  = 4'b1010;
   localparam logic [3:0] ALU_PASS = 4'b1111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [31:0] SIGN_FLIP = 32'h8000_0000;

`ifdef ALU_OP_SEQUENCER_SRA_EN
   localparam int PASS_W = 2;
`else
   localparam int PASS_W = 1;
`endif

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_t;
   typedef enum logic [1:0] {X_RAW, X_FLIP, X_ONES, X_TEMP} x_sel_t;
   typedef enum logic [2:0] {Y_RAW, Y_FLIP, Y_SHAMT, Y_INV_SHAMT, Y_ALU} y_sel_t;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - maps funct3/funct7 and pass index onto an ALU op and operand selects
// ALU_OP_SEQUENCER_SRA_EN adds the pass/sign inputs that drive the SRA micro-sequence.
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [2:0]        funct3,
   input  logic              funct7_b5,
   input  logic              is_imm,
`ifdef ALU_OP_SEQUENCER_SRA_EN
   input  logic [PASS_W-1:0] pass,
   input  logic              x_msb,
`endif
   output logic [3:0]        operation,
   output x_sel_t            x_sel,
   output y_sel_t            y_sel,
   output logic              last_pass
);

   always_comb begin
      operation = ALU_PASS;
      x_sel     = X_RAW;
      y_sel     = Y_RAW;
      last_pass = 1'b1;
      case (funct3)
         F3_ADD:  operation = (!is_imm && funct7_b5) ? ALU_SUB : ALU_ADD;
         F3_SLL:  begin operation = ALU_SLL; y_sel = Y_SHAMT; end
         // Flipping both sign bits turns a signed compare into an unsigned one.
         F3_SLT:  begin operation = ALU_LTU; x_sel = X_FLIP; y_sel = Y_FLIP; end
         F3_SLTU: operation = ALU_LTU;
         F3_XOR:  operation = ALU_XOR;
         F3_SR: begin
            operation = ALU_SRL;
            y_sel     = Y_SHAMT;
`ifdef ALU_OP_SEQUENCER_SRA_EN
            // Negative SRA: logical shift, then OR in a mask of ones built by a left shift.
            if (funct7_b5 && x_msb) begin
               last_pass = 1'b0;
               if (pass == 2'd1) begin
                  operation = ALU_SLL;
                  x_sel     = X_ONES;
                  y_sel     = Y_INV_SHAMT;
               end else if (pass == 2'd2) begin
                  operation = ALU_OR;
                  x_sel     = X_TEMP;
                  y_sel     = Y_ALU;
                  last_pass = 1'b1;
               end
            end
`endif
         end
         F3_OR:   operation = ALU_OR;
         F3_AND:  operation = ALU_AND;
         default: operation = ALU_PASS;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sequences RV32I reg/imm arithmetic through an external combinational ALU
// ALU_OP_SEQUENCER_SRA_EN enables the multi-pass arithmetic right shift.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      funct3,
   input  logic            funct7_b5,
   input  logic            is_imm,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic [3:0]      alu_operation,
   output logic [XLEN-1:0] alu_in_x,
   output logic [XLEN-1:0] alu_in_y,
   input  logic [XLEN-1:0] alu_out_s,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic            rsp_zero
);

   state_t              state;
   logic [PASS_W-1:0]   step;
   logic                last_r;
   logic [2:0]          f3_r;
   logic                f7_r;
   logic                imm_r;
   logic [XLEN-1:0]     x_r;
   logic [XLEN-1:0]     y_r;
`ifdef ALU_OP_SEQUENCER_SRA_EN
   logic [XLEN-1:0]     tmp_r;
`endif
   logic [3:0]          dec_op;
   x_sel_t              dec_x_sel;
   y_sel_t              dec_y_sel;
   logic                dec_last;
   logic [XLEN-1:0]     shamt;
   logic [XLEN-1:0]     x_mux;
   logic [XLEN-1:0]     y_mux;

   alu_seq_decode u_decode (
      .funct3    (f3_r),
      .funct7_b5 (f7_r),
      .is_imm    (imm_r),
`ifdef ALU_OP_SEQUENCER_SRA_EN
      .pass      (step),
      .x_msb     (x_r[XLEN-1]),
`endif
      .operation (dec_op),
      .x_sel     (dec_x_sel),
      .y_sel     (dec_y_sel),
      .last_pass (dec_last)
   );

   assign shamt     = {{(XLEN-SHAMT_W){1'b0}}, y_r[SHAMT_W-1:0]};
   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_DONE);

   always_comb begin
      x_mux = x_r;
      case (dec_x_sel)
         X_FLIP:  x_mux = x_r ^ SIGN_FLIP;
         X_ONES:  x_mux = '1;
`ifdef ALU_OP_SEQUENCER_SRA_EN
         X_TEMP:  x_mux = tmp_r;
`endif
         default: x_mux = x_r;
      endcase
   end

   // Y_INV_SHAMT yields 32 for sh=0 so the ones-mask shifts out completely.
   always_comb begin
      y_mux = y_r;
      case (dec_y_sel)
         Y_FLIP:      y_mux = y_r ^ SIGN_FLIP;
         Y_SHAMT:     y_mux = shamt;
         Y_INV_SHAMT: y_mux = XLEN'(XLEN) - shamt;
         Y_ALU:       y_mux = alu_out_s;
         default:     y_mux = y_r;
      endcase
   end

   // step 0 issues pass 0; each later step captures the previous pass and issues the next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         step          <= '0;
         last_r        <= 1'b0;
         f3_r          <= '0;
         f7_r          <= 1'b0;
         imm_r         <= 1'b0;
         x_r           <= '0;
         y_r           <= '0;
         alu_operation <= ALU_PASS;
         alu_in_x      <= '0;
         alu_in_y      <= '0;
         rsp_result    <= '0;
         rsp_zero      <= 1'b0;
`ifdef ALU_OP_SEQUENCER_SRA_EN
         tmp_r         <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  f3_r  <= funct3;
                  f7_r  <= funct7_b5;
                  imm_r <= is_imm;
                  x_r   <= rs1_val;
                  y_r   <= rs2_val;
                  step  <= '0;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (step != '0 && last_r) begin
                  rsp_result    <= alu_out_s;
                  rsp_zero      <= (alu_out_s == '0);
                  alu_operation <= ALU_PASS;
                  state         <= ST_DONE;
               end else begin
                  alu_operation <= dec_op;
                  alu_in_x      <= x_mux;
                  alu_in_y      <= y_mux;
                  last_r        <= dec_last;
                  step          <= step + 1'b1;
               end
`ifdef ALU_OP_SEQUENCER_SRA_EN
               tmp_r <= alu_out_s;
`endif
            end
            ST_DONE: begin
               if (rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with a behavioural ALU
// Honours ALU_OP_SEQUENCER_SRA_EN when computing expected SRA results and latencies.
module tb_alu_op_sequencer;

`ifdef ALU_OP_SEQUENCER_SRA_EN
   localparam bit SRA_EN = 1'b1;
`else
   localparam bit SRA_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  funct3 = '0;
   logic        funct7_b5 = 1'b0;
   logic        is_imm = 1'b0;
   logic [31:0] rs1_val = '0;
   logic [31:0] rs2_val = '0;
   logic [3:0]  alu_operation;
   logic [31:0] alu_in_x;
   logic [31:0] alu_in_y;
   logic [31:0] alu_out_s;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic        rsp_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  f3;
      logic        f7;
      logic        imm;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] res;
      logic        z;
      int          lat;
   } vec_t;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .funct3(funct3), .funct7_b5(funct7_b5), .is_imm(is_imm),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .alu_operation(alu_operation),
      .alu_in_x(alu_in_x), .alu_in_y(alu_in_y), .alu_out_s(alu_out_s),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero)
   );

   always_comb begin
      case (alu_operation)
         4'b0000: alu_out_s = alu_in_x & alu_in_y;
         4'b0001: alu_out_s = alu_in_x | alu_in_y;
         4'b0010: alu_out_s = alu_in_x + alu_in_y;
         4'b0110: alu_out_s = alu_in_x - alu_in_y;
         4'b0111: alu_out_s = {31'b0, alu_in_x < alu_in_y};
         4'b1100: alu_out_s = ~(alu_in_x | alu_in_y);
         4'b1000: alu_out_s = alu_in_x << alu_in_y;
         4'b1001: alu_out_s = alu_in_x >> alu_in_y;
         4'b1010: alu_out_s = alu_in_x ^ alu_in_y;
         4'b1111: alu_out_s = alu_in_x;
         default: alu_out_s = 32'h0;
      endcase
   end

   function automatic logic [31:0] model_result(input logic [2:0] f3, input logic f7, input logic imm,
                                                input logic [31:0] x, input logic [31:0] y);
      logic [31:0] sra;
      sra = $signed(x) >>> y[4:0];
      case (f3)
         3'd0:    return (!imm && f7) ? x - y : x + y;
         3'd1:    return x << y[4:0];
         3'd2:    return {31'b0, $signed(x) < $signed(y)};
         3'd3:    return {31'b0, x < y};
         3'd4:    return x ^ y;
         3'd5:    return (SRA_EN && f7) ? sra : x >> y[4:0];
         3'd6:    return x | y;
         default: return x & y;
      endcase
   endfunction

   function automatic int model_latency(input logic [2:0] f3, input logic f7, input logic [31:0] x);
      return (SRA_EN && f3 == 3'd5 && f7 && x[31]) ? 4 : 2;
   endfunction

   task automatic run_op(input logic [2:0] f3, input logic f7, input logic imm,
                         input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output logic z, output int lat);
      @(negedge clk);
      funct3 = f3; funct7_b5 = f7; is_imm = imm; rs1_val = x; rs2_val = y; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 8 && lat < 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (rsp_valid) lat = k;
      end
      res = rsp_result;
      z   = rsp_zero;
      if (lat >= 0) begin
         rsp_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result got %h want 0", rsp_result); end
      checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero got %b want 0", rsp_zero); end
      checks++; if (alu_operation !== 4'b1111) begin errors++; $display("FAIL reset_alu_op got %b want 1111", alu_operation); end
      checks++; if (alu_in_x !== 32'h0 || alu_in_y !== 32'h0) begin
         errors++; $display("FAIL reset_alu_in got x=%h y=%h want 0 0", alu_in_x, alu_in_y);
      end
      rst_n = 1'b1;
   endtask

   task automatic run_table(input string name, input vec_t v[$]);
      logic [31:0] r; logic z; int lat;
      foreach (v[i]) begin
         run_op(v[i].f3, v[i].f7, v[i].imm, v[i].x, v[i].y, r, z, lat);
         checks++; if (r !== v[i].res) begin errors++; $display("FAIL %s[%0d]_result got %h want %h", name, i, r, v[i].res); end
         checks++; if (z !== v[i].z) begin errors++; $display("FAIL %s[%0d]_zero got %b want %b", name, i, z, v[i].z); end
         checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL %s[%0d]_latency got %0d want %0d", name, i, lat, v[i].lat); end
      end
   endtask

   task automatic test_add_sub();
      vec_t v[$];
      v.push_back('{3'd0, 1'b1, 1'b0, 32'd5, 32'd3, 32'd2, 1'b0, 2});
      v.push_back('{3'd0, 1'b1, 1'b1, 32'd5, 32'd3, 32'd8, 1'b0, 2});
      v.push_back('{3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 2});
      run_table("add_sub", v);
   endtask

   task automatic test_compare();
      vec_t v[$];
      v.push_back('{3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 2});
      v.push_back('{3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 2});
      v.push_back('{3'd2, 1'b0, 1'b0, 32'd7, 32'd7, 32'd0, 1'b1, 2});
      run_table("compare", v);
   endtask

   task automatic test_shift();
      vec_t v[$];
      v.push_back('{3'd1, 1'b0, 1'b0, 32'd1, 32'h21, 32'd2, 1'b0, 2});
      v.push_back('{3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 2});
      run_table("shift", v);
   endtask

   task automatic test_sra();
      vec_t v[$];
      v.push_back('{3'd5, 1'b1, 1'b0, 32'hF000_0000, 32'd4,
                    SRA_EN ? 32'hFF00_0000 : 32'h0F00_0000, 1'b0, SRA_EN ? 4 : 2});
      v.push_back('{3'd5, 1'b1, 1'b0, 32'hF000_0000, 32'd0, 32'hF000_0000, 1'b0, SRA_EN ? 4 : 2});
      v.push_back('{3'd5, 1'b1, 1'b0, 32'h7000_0000, 32'd4, 32'h0700_0000, 1'b0, 2});
      v.push_back('{3'd5, 1'b1, 1'b1, 32'h8000_0001, 32'd31,
                    SRA_EN ? 32'hFFFF_FFFF : 32'h0000_0001, 1'b0, SRA_EN ? 4 : 2});
      run_table("sra", v);
   endtask

   task automatic test_random();
      vec_t v[$];
      vec_t e;
      for (int i = 0; i < 40; i++) begin
         e.f3  = 3'($urandom_range(0, 7));
         e.f7  = 1'($urandom_range(0, 1));
         e.imm = 1'($urandom_range(0, 1));
         e.x   = $urandom;
         e.y   = ($urandom_range(0, 3) == 0) ? e.x : $urandom;
         e.res = model_result(e.f3, e.f7, e.imm, e.x, e.y);
         e.z   = (e.res == 32'h0);
         e.lat = model_latency(e.f3, e.f7, e.x);
         v.push_back(e);
      end
      run_table("random", v);
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b, c, d;
      int lat;
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      @(negedge clk);
      funct3 = 3'd4; funct7_b5 = 1'b0; is_imm = 1'b0; rs1_val = a; rs2_val = b; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      funct3 = 3'd0; rs1_val = c; rs2_val = d;
      lat = -1;
      for (int k = 1; k <= 8 && lat < 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (rsp_valid) lat = k;
      end
      checks++; if (lat !== 2) begin errors++; $display("FAIL bp_first_latency got %0d want 2", lat); end
      for (int k = 0; k < 5; k++) begin
         checks++; if (rsp_valid !== 1'b1 || rsp_result !== (a ^ b) || req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d] got valid=%b result=%h ready=%b want 1 %h 0", k, rsp_valid, rsp_result, req_ready, a ^ b);
         end
         @(posedge clk);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL bp_return got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 8 && lat < 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (rsp_valid) lat = k;
      end
      checks++; if (lat !== 2 || rsp_result !== c + d) begin
         errors++; $display("FAIL bp_second got lat=%0d result=%h want 2 %h", lat, rsp_result, c + d);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_sra();
      logic [31:0] r; logic z; int lat;
      @(negedge clk);
      funct3 = 3'd5; funct7_b5 = 1'b1; is_imm = 1'b0; rs1_val = 32'hF000_0000; rs2_val = 32'd4; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_handshake got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
      end
      checks++; if (rsp_result !== 32'h0 || rsp_zero !== 1'b0) begin
         errors++; $display("FAIL midrst_rsp got result=%h zero=%b want 0 0", rsp_result, rsp_zero);
      end
      checks++; if (alu_operation !== 4'b1111 || alu_in_x !== 32'h0 || alu_in_y !== 32'h0) begin
         errors++; $display("FAIL midrst_alu got op=%b x=%h y=%h want 1111 0 0", alu_operation, alu_in_x, alu_in_y);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(3'd5, 1'b1, 1'b0, 32'hF000_0000, 32'd4, r, z, lat);
      checks++; if (r !== model_result(3'd5, 1'b1, 1'b0, 32'hF000_0000, 32'd4)) begin
         errors++; $display("FAIL midrst_after_result got %h want %h", r, model_result(3'd5, 1'b1, 1'b0, 32'hF000_0000, 32'd4));
      end
      checks++; if (lat !== model_latency(3'd5, 1'b1, 32'hF000_0000)) begin
         errors++; $display("FAIL midrst_after_latency got %0d want %0d", lat, model_latency(3'd5, 1'b1, 32'hF000_0000));
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_compare();
      test_shift();
      test_sra();
      test_random();
      test_backpressure();
      test_reset_mid_sra();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
